// File: rtl/sram_like_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_like_resp                                                  |
// | Purpose  : Memory-side responder for an SRAM-like req/addr_ok,             |
// |            data_ok/rdata bus. Word-addressed internal memory, in-order     |
// |            responses after a fixed LATENCY, up to QDEPTH outstanding.      |
// | Options  : SRAM_RESP_RAND_DELAY_EN adds 0..3 cycles of LFSR-driven extra   |
// |            latency per request, so the queue can fill and exercise         |
// |            addr_ok backpressure.                                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_like_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      wr,
  input  logic [31:0]               addr,
  input  logic [3:0]                wstrb,
  input  logic [31:0]               wdata,
  output logic                      addr_ok,
  output logic                      data_ok,
  output logic [31:0]               rdata,
  output logic [$clog2(QDEPTH):0]   outstanding
);

  localparam int               C_PTR_W = $clog2(QDEPTH);
  // Countdown must hold LATENCY-1 plus up to 3 extra random cycles.
  localparam int               C_CNT_W = 5;
  localparam int               C_WORDS = 1 << ADDR_W;
  localparam logic [C_PTR_W:0] C_FULL  = (C_PTR_W + 1)'(QDEPTH);

  // Backing store (not reset) and response queue payload.
  logic [31:0]        mem      [C_WORDS];
  logic               q_wr_q   [QDEPTH];
  logic [31:0]        q_data_q [QDEPTH];
  logic [C_CNT_W-1:0] q_cd_q   [QDEPTH];

  logic [C_PTR_W-1:0] head_q, head_d;
  logic [C_PTR_W-1:0] tail_q, tail_d;
  logic [C_PTR_W:0]   cnt_q, cnt_d;
  logic               data_ok_q, data_ok_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               w_accept;
  logic [ADDR_W-1:0]  w_idx;
  logic [31:0]        w_rd_word;
  logic [C_CNT_W-1:0] w_init_cd;
  logic [C_CNT_W-1:0] w_push_cd;
  logic               w_head_ready;
  logic               w_bypass;
  logic               w_retire;
  logic [QDEPTH-1:0]  w_slot_valid;
  logic               w_unused_addr;

  assign addr_ok   = !reset && (cnt_q < C_FULL);
  assign w_accept  = req && addr_ok;
  assign w_idx     = addr[ADDR_W+1:2];
  assign w_rd_word = mem[w_idx];
  // Upper address bits alias and the byte offset is meaningless for words.
  assign w_unused_addr = &{1'b0, addr[31:ADDR_W+2], addr[1:0]};

`ifdef SRAM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr_q;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign w_init_cd = C_CNT_W'(LATENCY - 1) + {3'b000, lfsr_q[1:0]};

  // Free-running delay generator, reseeded on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], w_lfsr_fb};
    end
  end
`else
  assign w_init_cd = C_CNT_W'(LATENCY - 1);
`endif

  // The stored countdown is the value for the cycle after the push, so the
  // accept-cycle count is consumed by the push itself.
  assign w_push_cd = (w_init_cd != '0) ? (w_init_cd - C_CNT_W'(1)) : '0;

  // A slot is live when its distance from the head is below the fill count.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot_valid
    logic [C_PTR_W-1:0] w_off;
    assign w_off            = C_PTR_W'(gi) - head_q;
    assign w_slot_valid[gi] = ({1'b0, w_off} < cnt_q);
  end

  // Head is due this edge; an empty queue lets a zero-countdown accept
  // respond straight away so LATENCY=1 still meets its timing.
  assign w_head_ready = (cnt_q != '0) && (q_cd_q[head_q] == '0);
  assign w_bypass     = (cnt_q == '0) && w_accept && (w_init_cd == '0);
  assign w_retire     = w_head_ready || w_bypass;

  // Next-state for pointers, fill count and the registered response.
  always_comb begin
    data_ok_d = w_retire;
    rdata_d   = 32'h0;
    head_d    = head_q + C_PTR_W'(w_retire);
    tail_d    = tail_q + C_PTR_W'(w_accept);
    cnt_d     = cnt_q + (C_PTR_W + 1)'(w_accept) - (C_PTR_W + 1)'(w_retire);
    if (w_head_ready) begin
      rdata_d = q_wr_q[head_q] ? 32'h0 : q_data_q[head_q];
    end else if (w_bypass) begin
      rdata_d = wr ? 32'h0 : w_rd_word;
    end
  end

  // Control state with synchronous reset; pending entries are simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  // Queue payload: age live entries, then capture the new request at the tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (w_slot_valid[i] && (q_cd_q[i] != '0)) begin
        q_cd_q[i] <= q_cd_q[i] - C_CNT_W'(1);
      end
    end
    if (w_accept) begin
      q_wr_q[tail_q]   <= wr;
      q_data_q[tail_q] <= w_rd_word;
      q_cd_q[tail_q]   <= w_push_cd;
    end
  end

  // Byte-masked write commit at the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_ok     = data_ok_q;
  assign rdata       = rdata_q;
  assign outstanding = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_like_resp                                               |
// | Purpose  : Self-checking bench for sram_like_resp: two instances           |
// |            (LATENCY=2 and LATENCY=8), table vectors, hand sequences for    |
// |            full queue and mid-flight reset, random traffic, scoreboard.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_like_resp;

  localparam int AW   = 10;
  localparam int QD   = 4;
  localparam int LAT0 = 2;
  localparam int LAT1 = 8;
  localparam int OW   = $clog2(QD) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_v;
  logic          wr;
  logic [31:0]   addr;
  logic [3:0]    wstrb;
  logic [31:0]   wdata;
  logic [1:0]    aok_v;
  logic [1:0]    dok_v;
  logic [31:0]   rdata0, rdata1;
  logic [OW-1:0] out0, out1;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int dok_cnt1 = 0;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } sb_t;
  sb_t sb0[$];
  sb_t sb1[$];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [21];
  int   acc_t [21];

  logic [31:0] mdl0 [1 << AW];
  logic [31:0] mdl1 [1 << AW];

  sram_like_resp #(.ADDR_W(AW), .LATENCY(LAT0), .QDEPTH(QD)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .wr(wr), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(aok_v[0]), .data_ok(dok_v[0]),
    .rdata(rdata0), .outstanding(out0)
  );

  sram_like_resp #(.ADDR_W(AW), .LATENCY(LAT1), .QDEPTH(QD)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .wr(wr), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(aok_v[1]), .data_ok(dok_v[1]),
    .rdata(rdata1), .outstanding(out1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected end of test", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic on_resp(input int k, input logic [31:0] rd);
    sb_t e;
    int  lat;
    lat = (k == 0) ? LAT0 : LAT1;
    if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL spurious_data_ok dut%0d: got data_ok=1 rdata=0x%08h, expected no response", k, rd);
    end else begin
      if (k == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
      chk($sformatf("rdata dut%0d", k), rd, e.exp);
`ifdef SRAM_RESP_RAND_DELAY_EN
      n_checks++;
      if (cyc < e.acc + lat) begin
        n_fail++;
        $display("FAIL latency dut%0d: got %0d cycles, expected at least %0d", k, cyc - e.acc, lat);
      end
`else
      chk($sformatf("data_ok cycle dut%0d", k), cyc, e.acc + lat);
`endif
    end
  endtask

  // Response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (dok_v[0]) on_resp(0, rdata0);
    if (dok_v[1]) begin
      dok_cnt1++;
      on_resp(1, rdata1);
    end
  end

  // Drive one request (entered at posedge+1), wait for accept, push expectation.
  task automatic send(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit use_t, input logic [31:0] texp,
                      output int acc);
    logic [31:0] e;
    logic [31:0] m;
    int          idx;
    int          n;
    sb_t         ent;
    idx = int'(a[AW+1:2]);
    m   = (k == 0) ? mdl0[idx] : mdl1[idx];
    if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      if (k == 0) mdl0[idx] = m;
      else        mdl1[idx] = m;
      e = 32'h0;
    end else begin
      e = m;
    end
    if (use_t) e = texp;
    wr = w; addr = a; wstrb = s; wdata = d;
    req_v = 2'b00;
    req_v[k] = 1'b1;
    n   = 0;
    acc = -1;
    @(negedge clk);
    while (!aok_v[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (aok_v[k]) begin
      acc     = cyc;
      ent.exp = e;
      ent.acc = cyc;
      if (k == 0) sb0.push_back(ent);
      else        sb1.push_back(ent);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: got addr_ok=0 for %0d cycles, expected accept", k, n);
    end
    @(posedge clk);
    #1;
    req_v = 2'b00;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (((k == 0) ? sb0.size() : sb1.size()) != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (((k == 0) ? sb0.size() : sb1.size()) != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout dut%0d: got %0d pending, expected 0", k,
               (k == 0) ? sb0.size() : sb1.size());
    end
  endtask

  initial begin
    int          a;
    int          acc_f [8];
    int          base;
    int          idx;
    logic [31:0] ra;

    reset = 1'b1; req_v = 2'b00; wr = 1'b0; addr = '0; wstrb = '0; wdata = '0;

    vt[0] = '{1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vt[1] = '{1'b0, 32'h10, 4'hF, 32'h0,         32'hDEAD_BEEF};
    vt[2] = '{1'b1, 32'h20, 4'hF, 32'h1122_3344, 32'h0};
    vt[3] = '{1'b1, 32'h20, 4'h5, 32'hAABB_CCDD, 32'h0};
    vt[4] = '{1'b0, 32'h20, 4'hF, 32'h0,         32'h11BB_33DD};
    for (int i = 0; i < 8; i++) begin
      vt[5 + i]  = '{1'b1, 32'(4 * i), 4'hF, 32'(i), 32'h0};
      vt[13 + i] = '{1'b0, 32'(4 * i), 4'hF, 32'h0,  32'(i)};
    end

    // Reset state
    @(negedge clk);
    chk("addr_ok0 in reset", {31'b0, aok_v[0]}, 32'h0);
    chk("addr_ok1 in reset", {31'b0, aok_v[1]}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("data_ok0 after reset", {31'b0, dok_v[0]}, 32'h0);
    chk("rdata0 after reset", rdata0, 32'h0);
    chk("outstanding0 after reset", 32'(out0), 32'h0);
    chk("addr_ok0 after reset", {31'b0, aok_v[0]}, 32'h1);
    chk("data_ok1 after reset", {31'b0, dok_v[1]}, 32'h0);
    chk("rdata1 after reset", rdata1, 32'h0);
    chk("outstanding1 after reset", 32'(out1), 32'h0);
    @(posedge clk); #1;

    // Table vectors, back-to-back on the LATENCY=2 instance
    for (int i = 0; i < 21; i++) begin
      send(0, vt[i].w, vt[i].a, vt[i].s, vt[i].d, 1'b1, vt[i].exp, acc_t[i]);
    end
`ifndef SRAM_RESP_RAND_DELAY_EN
    chk("wr->rd back-to-back accept", acc_t[1], acc_t[0] + 1);
    for (int i = 14; i < 21; i++) begin
      chk($sformatf("b2b read accept %0d", i - 13), acc_t[i], acc_t[i - 1] + 1);
    end
`endif
    drain(0);

    // Address aliasing: upper bits above ADDR_W+1 are ignored
    send(0, 1'b1, 32'h0000_1004, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0, a);
    send(0, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, a);
    drain(0);

    // Full queue on the LATENCY=8 instance
    for (int i = 0; i < 4; i++) begin
      send(1, 1'b1, 32'(4 * i), 4'hF, 32'h100 + 32'(i), 1'b0, 32'h0, acc_f[i]);
    end
`ifndef SRAM_RESP_RAND_DELAY_EN
    for (int i = 1; i < 4; i++) chk($sformatf("full fill accept %0d", i), acc_f[i], acc_f[i - 1] + 1);
`endif
    @(negedge clk);
    chk("full addr_ok", {31'b0, aok_v[1]}, 32'h0);
    chk("full outstanding", 32'(out1), 32'h4);
    @(posedge clk); #1;
    send(1, 1'b1, 32'h10, 4'hF, 32'h104, 1'b0, 32'h0, acc_f[4]);
`ifndef SRAM_RESP_RAND_DELAY_EN
    chk("full reaccept cycle", acc_f[4], acc_f[0] + LAT1);
`endif
    for (int i = 5; i < 8; i++) begin
      send(1, 1'b1, 32'(4 * i), 4'hF, 32'h100 + 32'(i), 1'b0, 32'h0, acc_f[i]);
    end
    drain(1);

    // Reset with three reads in flight
    for (int i = 1; i < 4; i++) send(1, 1'b0, 32'(4 * i), 4'hF, 32'h0, 1'b0, 32'h0, a);
    reset = 1'b1;
    sb0.delete();
    sb1.delete();
    base = dok_cnt1;
    @(negedge clk);
    chk("pre-reset outstanding1", 32'(out1), 32'h3);
    chk("addr_ok1 during mid reset", {31'b0, aok_v[1]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("outstanding1 after mid reset", 32'(out1), 32'h0);
    chk("data_ok1 count after mid reset", 32'(dok_cnt1 - base), 32'h0);
    @(posedge clk); #1;
    send(1, 1'b0, 32'h14, 4'hF, 32'h0, 1'b1, 32'h105, a);
    drain(1);

    // Random traffic with aliased addresses against the model
    for (int i = 16; i < 32; i++) begin
      send(0, 1'b1, 32'(4 * i), 4'hF, $urandom, 1'b0, 32'h0, a);
    end
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(2, 1)) begin
          @(posedge clk); #1;
        end
      end
      idx = $urandom_range(31, 16);
      ra  = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
      send(0, 1'($urandom_range(1)), ra, 4'($urandom_range(15)), $urandom, 1'b0, 32'h0, a);
    end
    drain(0);

    repeat (4) begin
      @(posedge clk); #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
